alarm_multi_controller: RTL

- Parametrised master controller for the alarm clock: owns display-mode selection plus NUM_ALARMS independent alarm channels.
- Adds edge-triggered match detection, priority arbitration, snooze with a repeat limit, dismiss, and ring auto-timeout.
- Sits between the timekeeping/alarm-register blocks (time inputs) and the display mux and buzzer driver (outputs). Minute pacing comes from the timekeeper's one-cycle minute strobe.

---
 rtl/alarm_pkg.sv | 17 +
 rtl/alarm_match_arbiter.sv | 50 +++++
 rtl/alarm_multi_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller slice: FSM state encoding,
// display-mode codes and the common counter width.
package alarm_pkg;

    localparam int CNT_W = 6;

    localparam logic [1:0] DISP_TIME     = 2'd0;
    localparam logic [1:0] DISP_ALARM    = 2'd1;
    localparam logic [1:0] DISP_SET_TIME = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

endpackage

// File: rtl/alarm_match_arbiter.sv
// Per-channel alarm compare with rising-edge detection and a lowest-index
// priority encoder, so each match fires at most once while the time holds.
module alarm_match_arbiter #(
    parameter int NUM_ALARMS = 2,
    parameter int TIME_W     = 16,
    parameter int IDX_W      = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [TIME_W-1:0]            cur_time,
    input  logic [NUM_ALARMS*TIME_W-1:0] alarm_time,
    input  logic [NUM_ALARMS-1:0]        enable,
    input  logic                         change_time,
    output logic                         trigger_valid,
    output logic [IDX_W-1:0]             trigger_idx
);

    logic [NUM_ALARMS-1:0] match;
    logic [NUM_ALARMS-1:0] match_prev;
    logic [NUM_ALARMS-1:0] trigger;

    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            match[k] = enable[k] && (cur_time == alarm_time[k*TIME_W +: TIME_W]) && !change_time;
        end
    end

    // History resets to all ones so a time already matching at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_prev <= '1;
        end else begin
            match_prev <= match;
        end
    end

    assign trigger = match & ~match_prev;

    always_comb begin
        trigger_valid = |trigger;
        trigger_idx   = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (trigger[k]) begin
                trigger_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/alarm_multi_controller.sv
// Master alarm controller: display-mode selection plus a ring/snooze/dismiss FSM
// shared by NUM_ALARMS channels, paced by the timekeeper's minute strobe.
module alarm_multi_controller
    import alarm_pkg::*;
#(
    parameter int  NUM_ALARMS       = 2,
    parameter int  TIME_W           = 16,
    parameter int  SNOOZE_MIN       = 9,
    parameter int  MAX_SNOOZES      = 3,
    parameter int  RING_TIMEOUT_MIN = 10,
    localparam int IDX_W            = $clog2((NUM_ALARMS > 2) ? NUM_ALARMS : 2)
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic                         i_Change_Time,
    input  logic                         i_Change_Alarm,
    input  logic [IDX_W-1:0]             i_Alarm_Sel,
    input  logic [NUM_ALARMS-1:0]        i_Alarm_Enable,
    input  logic                         i_Snooze,
    input  logic                         i_Dismiss,
    input  logic                         i_Minute_Tick,
    input  logic [TIME_W-1:0]            i_Time,
    input  logic [NUM_ALARMS*TIME_W-1:0] i_Alarm_Time,
    output logic [1:0]                   o_Display_Mode,
    output logic [IDX_W-1:0]             o_Display_Alarm_Idx,
    output logic                         o_Alarm_On,
    output logic [IDX_W-1:0]             o_Alarm_Active_Idx,
    output logic                         o_Snoozing,
    output logic [NUM_ALARMS-1:0]        o_Alarm_Enabled
);

    localparam int               EN_W         = 1 << IDX_W;
    localparam logic [IDX_W:0]   NUM_ALARMS_L = (IDX_W + 1)'(NUM_ALARMS);
    localparam logic [CNT_W-1:0] SNOOZE_C     = CNT_W'(SNOOZE_MIN);
    localparam logic [CNT_W-1:0] MAX_SNOOZE_C = CNT_W'(MAX_SNOOZES);
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(RING_TIMEOUT_MIN);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  active_q, active_d;
    logic [CNT_W-1:0]  snooze_cnt_q, snooze_cnt_d;
    logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0]  snooze_timer_q, snooze_timer_d;
    logic [1:0]        disp_mode_q;
    logic [IDX_W-1:0]  disp_idx_q;
    logic              trigger_valid;
    logic [IDX_W-1:0]  trigger_idx;
    logic [EN_W-1:0]   enable_pad;
    logic              active_enabled;

    alarm_match_arbiter #(
        .NUM_ALARMS (NUM_ALARMS),
        .TIME_W     (TIME_W),
        .IDX_W      (IDX_W)
    ) u_arbiter (
        .clk           (i_Clk),
        .reset         (i_Reset),
        .cur_time      (i_Time),
        .alarm_time    (i_Alarm_Time),
        .enable        (i_Alarm_Enable),
        .change_time   (i_Change_Time),
        .trigger_valid (trigger_valid),
        .trigger_idx   (trigger_idx)
    );

    // Padding keeps the active-channel lookup in range for non power-of-two channel counts.
    assign enable_pad     = EN_W'(i_Alarm_Enable);
    assign active_enabled = enable_pad[active_q];

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            disp_mode_q <= DISP_TIME;
            disp_idx_q  <= '0;
        end else begin
            if (i_Change_Time) begin
                disp_mode_q <= DISP_SET_TIME;
            end else if (i_Change_Alarm) begin
                disp_mode_q <= DISP_ALARM;
            end else begin
                disp_mode_q <= DISP_TIME;
            end
            disp_idx_q <= ({1'b0, i_Alarm_Sel} < NUM_ALARMS_L) ? i_Alarm_Sel : '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q        <= IDLE;
            active_q       <= '0;
            snooze_cnt_q   <= '0;
            timeout_cnt_q  <= '0;
            snooze_timer_q <= '0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            snooze_cnt_q   <= snooze_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            snooze_timer_q <= snooze_timer_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        snooze_cnt_d   = snooze_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        snooze_timer_d = snooze_timer_q;
        case (state_q)
            IDLE: begin
                if (trigger_valid) begin
                    state_d       = RINGING;
                    active_d      = trigger_idx;
                    snooze_cnt_d  = '0;
                    timeout_cnt_d = '0;
                end
            end
            RINGING: begin
                if (!active_enabled || i_Dismiss) begin
                    state_d = IDLE;
                end else if (i_Snooze && (snooze_cnt_q < MAX_SNOOZE_C)) begin
                    state_d        = SNOOZE;
                    snooze_cnt_d   = snooze_cnt_q + 1'b1;
                    snooze_timer_d = SNOOZE_C;
                end else if (i_Minute_Tick) begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                    if (timeout_cnt_q + 1'b1 == TIMEOUT_C) begin
                        state_d = IDLE;
                    end
                end
            end
            SNOOZE: begin
                if (!active_enabled || i_Dismiss) begin
                    state_d = IDLE;
                end else if (i_Minute_Tick) begin
                    snooze_timer_d = snooze_timer_q - 1'b1;
                    if (snooze_timer_q == CNT_W'(1)) begin
                        state_d       = RINGING;
                        timeout_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_Display_Mode      = disp_mode_q;
    assign o_Display_Alarm_Idx = disp_idx_q;
    assign o_Alarm_On          = (state_q == RINGING);
    assign o_Snoozing          = (state_q == SNOOZE);
    assign o_Alarm_Active_Idx  = active_q;
    assign o_Alarm_Enabled     = i_Alarm_Enable;

endmodule
